// File: rtl/maze_query_arbiter.sv
// maze_query_arbiter: shares one direction_flag wall lookup between pacman and the monsters.
// Build option: define MAZE_ARB_FIXED_PRIO_EN for fixed priority (index 0 always wins).
module maze_query_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int COORD_W    = 9,
   parameter int FLAG_W     = 3,
   parameter int LOOKUP_LAT = 1
) (
   input  logic                       clk_50mhz,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*COORD_W-1:0] req_x,
   input  logic [NUM_REQ*COORD_W-1:0] req_y,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [FLAG_W-1:0]          rsp_flag_L,
   output logic [FLAG_W-1:0]          rsp_flag_U,
   output logic [FLAG_W-1:0]          rsp_flag_R,
   output logic [FLAG_W-1:0]          rsp_flag_D,
   output logic                       busy,
   output logic [COORD_W-1:0]         lk_x,
   output logic [COORD_W-1:0]         lk_y,
   input  logic [FLAG_W-1:0]          lk_flag_L,
   input  logic [FLAG_W-1:0]          lk_flag_U,
   input  logic [FLAG_W-1:0]          lk_flag_R,
   input  logic [FLAG_W-1:0]          lk_flag_D
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t              state_reg, state_next;
   logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
   logic [NUM_REQ-1:0]  rsp_valid_reg, rsp_valid_next;
   logic [FLAG_W-1:0]   flag_l_reg, flag_l_next, flag_u_reg, flag_u_next;
   logic [FLAG_W-1:0]   flag_r_reg, flag_r_next, flag_d_reg, flag_d_next;
   logic                busy_reg, busy_next;
   logic [COORD_W-1:0]  lk_x_reg, lk_x_next, lk_y_reg, lk_y_next;
   logic [IDX_W-1:0]    winner_reg, winner_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;

   logic [COORD_W-1:0]  x_arr [NUM_REQ];
   logic [COORD_W-1:0]  y_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign x_arr[gi] = req_x[gi*COORD_W +: COORD_W];
         assign y_arr[gi] = req_y[gi*COORD_W +: COORD_W];
      end
   endgenerate

`ifdef MAZE_ARB_FIXED_PRIO_EN
   // Lowest set index wins; the descending scan leaves the smallest index last.
   always_comb begin
      pick_idx = '0;
      pick_any = |req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[IDX_W'(k)]) pick_idx = IDX_W'(k);
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
   int               idx;

   // Scan offsets from rr_ptr downward so the nearest set bit at or above rr_ptr wins.
   always_comb begin
      pick_idx = '0;
      pick_any = |req;
      idx      = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_reg) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx[IDX_W-1:0]]) pick_idx = idx[IDX_W-1:0];
      end
   end
`endif

   always_comb begin
      state_next     = state_reg;
      gnt_next       = '0;
      rsp_valid_next = '0;
      flag_l_next    = flag_l_reg;
      flag_u_next    = flag_u_reg;
      flag_r_next    = flag_r_reg;
      flag_d_next    = flag_d_reg;
      lk_x_next      = lk_x_reg;
      lk_y_next      = lk_y_reg;
      winner_next    = winner_reg;
      cnt_next       = cnt_reg;
`ifndef MAZE_ARB_FIXED_PRIO_EN
      rr_ptr_next    = rr_ptr_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (pick_any) begin
               state_next  = ST_WAIT;
               gnt_next    = ONE_HOT0 << pick_idx;
               lk_x_next   = x_arr[pick_idx];
               lk_y_next   = y_arr[pick_idx];
               winner_next = pick_idx;
               cnt_next    = CNT_W'(LOOKUP_LAT);
            end
         end
         ST_WAIT: begin
            if (cnt_reg == '0) begin
               flag_l_next    = lk_flag_L;
               flag_u_next    = lk_flag_U;
               flag_r_next    = lk_flag_R;
               flag_d_next    = lk_flag_D;
               rsp_valid_next = ONE_HOT0 << winner_reg;
               state_next     = ST_RESP;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
`ifndef MAZE_ARB_FIXED_PRIO_EN
            rr_ptr_next = (winner_reg == LAST_IDX) ? '0 : winner_reg + 1'b1;
`endif
         end
         default: state_next = ST_IDLE;
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         gnt_reg       <= '0;
         rsp_valid_reg <= '0;
         flag_l_reg    <= '0;
         flag_u_reg    <= '0;
         flag_r_reg    <= '0;
         flag_d_reg    <= '0;
         busy_reg      <= 1'b0;
         lk_x_reg      <= '0;
         lk_y_reg      <= '0;
         winner_reg    <= '0;
         cnt_reg       <= '0;
`ifndef MAZE_ARB_FIXED_PRIO_EN
         rr_ptr_reg    <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         gnt_reg       <= gnt_next;
         rsp_valid_reg <= rsp_valid_next;
         flag_l_reg    <= flag_l_next;
         flag_u_reg    <= flag_u_next;
         flag_r_reg    <= flag_r_next;
         flag_d_reg    <= flag_d_next;
         busy_reg      <= busy_next;
         lk_x_reg      <= lk_x_next;
         lk_y_reg      <= lk_y_next;
         winner_reg    <= winner_next;
         cnt_reg       <= cnt_next;
`ifndef MAZE_ARB_FIXED_PRIO_EN
         rr_ptr_reg    <= rr_ptr_next;
`endif
      end
   end

   assign gnt        = gnt_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_flag_L = flag_l_reg;
   assign rsp_flag_U = flag_u_reg;
   assign rsp_flag_R = flag_r_reg;
   assign rsp_flag_D = flag_d_reg;
   assign busy       = busy_reg;
   assign lk_x       = lk_x_reg;
   assign lk_y       = lk_y_reg;

endmodule

// File: tb/tb_maze_query_arbiter.sv
// Self-checking bench for maze_query_arbiter: table-driven vectors, hand sequences and
// randomized transactions against a transaction-level arbitration model.
module tb_maze_query_arbiter;
   localparam int N   = 4;
   localparam int CW  = 9;
   localparam int FW  = 3;
   localparam int LAT = 1;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic          rst_n;
   logic [N-1:0]  req;
   logic [N*CW-1:0] req_x, req_y;
   logic [N-1:0]  gnt, rsp_valid;
   logic [FW-1:0] rf_l, rf_u, rf_r, rf_d;
   logic          busy;
   logic [CW-1:0] lk_x, lk_y;
   logic [FW-1:0] lf_l, lf_u, lf_r, lf_d;

   logic [CW-1:0] xs [N];
   logic [CW-1:0] ys [N];
   logic [2:0]    salt;
   logic [11:0]   last_flags;
   int            ptr;
   int            n_vec = 0;
   int            n_bad = 0;

   maze_query_arbiter #(.NUM_REQ(N), .COORD_W(CW), .FLAG_W(FW), .LOOKUP_LAT(LAT)) dut (
      .clk_50mhz(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
      .gnt(gnt), .rsp_valid(rsp_valid),
      .rsp_flag_L(rf_l), .rsp_flag_U(rf_u), .rsp_flag_R(rf_r), .rsp_flag_D(rf_d),
      .busy(busy), .lk_x(lk_x), .lk_y(lk_y),
      .lk_flag_L(lf_l), .lk_flag_U(lf_u), .lk_flag_R(lf_r), .lk_flag_D(lf_d)
   );

   always_comb begin
      req_x = '0;
      req_y = '0;
      for (int i = 0; i < N; i++) begin
         req_x[i*CW +: CW] = xs[i];
         req_y[i*CW +: CW] = ys[i];
      end
   end

   // Wall-flag model: {L,U,R,D} as a function of the cell and a salt.
   function automatic logic [11:0] look(input logic [8:0] x, input logic [8:0] y, input logic [2:0] s);
      logic [2:0] l, u, r, d;
      l = x[2:0] ^ y[2:0] ^ 3'd1;
      u = x[5:3] ^ y[5:3];
      r = x[8:6] ^ s;
      d = x[2:0] - y[2:0];
      return {l, u, r, d};
   endfunction

   // Lookup output is garbage until lk_x/lk_y have been steady for LAT cycles.
   logic [17:0] hist [8];
   logic        settled;
   logic [11:0] lf;
   always @(posedge clk) begin
      hist[0] <= {lk_x, lk_y};
      for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
   end
   always_comb begin
      settled = 1'b1;
      for (int k = 0; k < LAT; k++) if (hist[k] !== {lk_x, lk_y}) settled = 1'b0;
      lf = look(lk_x, lk_y, salt);
      if (!settled) lf = ~lf;
      {lf_l, lf_u, lf_r, lf_d} = lf;
   end

   // Arbitration rule: round-robin from ptr, or lowest index under fixed priority.
   function automatic int pick(input logic [N-1:0] m, input int p);
`ifdef MAZE_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (m[i]) return i + 0 * p;
`else
      for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
`endif
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      req = '0;
      for (int i = 0; i < n; i++) begin
         step();
         chk("idle_gnt", gnt, 0);
         chk("idle_rsp", rsp_valid, 0);
         chk("idle_busy", busy, 0);
         chk("idle_flags", {rf_l, rf_u, rf_r, rf_d}, last_flags);
      end
   endtask

   // Called in an IDLE cycle; ends in the IDLE cycle after RESP.
   task automatic do_txn(input logic [N-1:0] mask, input int w, input bit drop, input bit scr);
      logic [N-1:0] oh;
      logic [8:0]   wx, wy;
      logic [11:0]  ef;
      oh = '0;
      oh[w] = 1'b1;
      wx = xs[w];
      wy = ys[w];
      ef = look(wx, wy, salt);
      req = mask;
      step();
      chk("gnt", gnt, oh);
      chk("lk_x", lk_x, wx);
      chk("lk_y", lk_y, wy);
      chk("busy_wait", busy, 1);
      chk("rsp_in_wait", rsp_valid, 0);
      if (drop) req = mask & ~oh;
      if (scr) begin
         xs[w] = 9'($urandom_range(0, 511));
         ys[w] = 9'($urandom_range(0, 511));
      end
      for (int i = 0; i < LAT; i++) begin
         step();
         chk("gnt_wait", gnt, 0);
         chk("rsp_wait", rsp_valid, 0);
         chk("lk_x_hold", lk_x, wx);
         chk("lk_y_hold", lk_y, wy);
      end
      step();
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_flags", {rf_l, rf_u, rf_r, rf_d}, ef);
      chk("gnt_resp", gnt, 0);
      chk("busy_resp", busy, 1);
      $display("txn mask=%b winner=%0d x=%0d y=%0d flags=%h drop=%0d", mask, w, wx, wy, ef, drop);
      req = mask & ~oh;
      ptr = (w + 1) % N;
      last_flags = ef;
      salt = 3'($urandom_range(0, 7));
      step();
      chk("busy_idle", busy, 0);
      chk("rsp_idle", rsp_valid, 0);
      chk("flags_hold", {rf_l, rf_u, rf_r, rf_d}, last_flags);
   endtask

   typedef struct {
      logic [N-1:0] mask;
      bit           drop;
      bit           scr;
      int           exp_rr;
      int           exp_fp;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [N-1:0] pend;
      logic [N-1:0] oh;
      int w;

      tbl[0] = '{4'b1111, 1'b0, 1'b0, 1, 0};
      tbl[1] = '{4'b1111, 1'b0, 1'b0, 2, 0};
      tbl[2] = '{4'b1111, 1'b0, 1'b0, 3, 0};
      tbl[3] = '{4'b1111, 1'b0, 1'b0, 0, 0};
      tbl[4] = '{4'b1111, 1'b0, 1'b0, 1, 0};
      tbl[5] = '{4'b0100, 1'b1, 1'b1, 2, 2};
      tbl[6] = '{4'b1110, 1'b0, 1'b0, 3, 1};
      tbl[7] = '{4'b1110, 1'b0, 1'b1, 1, 1};

      rst_n = 1'b0;
      req   = '0;
      salt  = 3'd0;
      ptr   = 0;
      last_flags = '0;
      for (int i = 0; i < N; i++) begin
         xs[i] = '0;
         ys[i] = '0;
      end
      step();
      step();
      chk("rst_gnt", gnt, 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lk", {lk_x, lk_y}, 0);
      chk("rst_flags", {rf_l, rf_u, rf_r, rf_d}, 0);
      rst_n = 1'b1;
      idle_cycles(2);

      // Single pacman query at (180,180): expect L=1 U=0 R=2 D=0.
      xs[0] = 9'd180;
      ys[0] = 9'd180;
      do_txn(4'b0001, 0, 1'b0, 1'b0);
      chk("tp_flags", {rf_l, rf_u, rf_r, rf_d}, 12'b001_000_010_000);
      idle_cycles(1);

      xs[0] = 9'd20;  xs[1] = 9'd300; xs[2] = 9'd100; xs[3] = 9'd180;
      ys[0] = 9'd7;   ys[1] = 9'd45;  ys[2] = 9'd260; ys[3] = 9'd511;
      for (int v = 0; v < 8; v++) begin
`ifdef MAZE_ARB_FIXED_PRIO_EN
         w = tbl[v].exp_fp;
`else
         w = tbl[v].exp_rr;
`endif
         do_txn(tbl[v].mask, w, tbl[v].drop, tbl[v].scr);
      end

      // req[1] dropped after grant completes; req[3] raised only while busy is never granted.
      req = 4'b0010;
      step();
      chk("gnt_seq", gnt, 4'b0010);
      req = 4'b1000;
      for (int i = 0; i < LAT; i++) step();
      req = 4'b0000;
      step();
      chk("rsp_seq", rsp_valid, 4'b0010);
      last_flags = {rf_l, rf_u, rf_r, rf_d};
      chk("rsp_seq_flags", last_flags, look(xs[1], ys[1], salt));
      ptr = 2;
      idle_cycles(4);

      // Reset during WAIT aborts the transaction and returns the pointer to 0.
      w = pick(4'b1111, ptr);
      oh = '0;
      oh[w] = 1'b1;
      req = 4'b1111;
      step();
      chk("gnt_pre_rst", gnt, oh);
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", gnt, 0);
      chk("arst_busy", busy, 0);
      chk("arst_lk", {lk_x, lk_y}, 0);
      chk("arst_flags", {rf_l, rf_u, rf_r, rf_d}, 0);
      for (int i = 0; i < LAT + 2; i++) begin
         step();
         chk("rst_no_rsp", rsp_valid, 0);
      end
      rst_n = 1'b1;
      ptr = 0;
      last_flags = '0;
      do_txn(4'b1111, pick(4'b1111, 0), 1'b0, 1'b0);
      idle_cycles(1);

      // Randomized transactions with pending requesters that hold req until served.
      pend = '0;
      for (int t = 0; t < 60; t++) begin
         pend = pend | N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 3) == 0) pend[$urandom_range(0, N - 1)] = 1'b0;
         for (int i = 0; i < N; i++) begin
            xs[i] = 9'($urandom_range(0, 511));
            ys[i] = 9'($urandom_range(0, 511));
         end
         if (pend == '0) begin
            idle_cycles(1);
         end else begin
            w = pick(pend, ptr);
            do_txn(pend, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            pend[w] = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
               idle_cycles(1);
               if (pend != '0) begin
                  // Pending requesters keep req high through the gap.
                  n_vec = n_vec;
               end
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/maze_query_arbiter.md
Name: maze_query_arbiter

Overview:
- Shares one direction_flag wall-lookup instance between pacman and the monster instances; each requester needs L/U/R/D wall flags for its own (x,y).
- Requesters raise req with coordinates. The arbiter picks one, drives the shared lookup's x/y, waits the lookup latency, then returns the four flags with a one-cycle rsp_valid pulse to the winner.
- Sits between the game-logic movers and the single maze ROM/flag block, in the clk_50mhz domain.

Parameters:
- NUM_REQ, 4, number of requesters (index 0 = pacman, 1..3 = monsters); legal range 2..8.
- COORD_W, 9, width of x/y coordinates.
- FLAG_W, 3, width of each direction flag.
- LOOKUP_LAT, 1, clock cycles from lk_x/lk_y change to valid lk_flag_* at the lookup outputs; legal range 0..7.

Ports:
- clk_50mhz  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester query request; level, held until rsp_valid.
- req_x  in  NUM_REQ*COORD_W  packed x; requester i at bits [i*COORD_W +: COORD_W].
- req_y  in  NUM_REQ*COORD_W  packed y; same packing as req_x.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse when the requester's coordinates are captured.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse when rsp_flag_* hold that requester's result.
- rsp_flag_L/U/R/D  out  FLAG_W each  captured flags, broadcast to all requesters.
- busy  out  1  high in any state other than IDLE.
- lk_x, lk_y  out  COORD_W each  coordinates driven to the shared direction_flag.
- lk_flag_L/U/R/D  in  FLAG_W each  flags returned by the shared direction_flag.

Behaviour:
- Reset (asynchronous assert, synchronous release) clears the following: state=IDLE, gnt=0, rsp_valid=0, rsp_flag_*=0, lk_x=lk_y=0, busy=0, rr_ptr=0, wait counter=0.
- FSM states: IDLE, WAIT, RESP. All outputs are registered.
- IDLE, at least one req bit set, at edge of cycle T:
  - Select winner by round-robin: first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Set gnt to winner one-hot. Latch winner's req_x/req_y into lk_x/lk_y. Store winner index.
  - Load cnt=LOOKUP_LAT. Go to WAIT.
- IDLE with req=0: stay; outputs unchanged except gnt/rsp_valid=0.
- WAIT:
  - gnt is high only on the first WAIT cycle (T+1).
  - lk_x/lk_y held constant throughout WAIT.
  - If cnt==0: capture lk_flag_* into rsp_flag_*, set rsp_valid to winner one-hot, go to RESP. Otherwise decrement cnt.
  - WAIT therefore lasts LOOKUP_LAT+1 cycles (T+1 .. T+1+LOOKUP_LAT).
- RESP (cycle T+2+LOOKUP_LAT): rsp_valid high for this single cycle. rr_ptr <= (winner+1) mod NUM_REQ. Go to IDLE.
- Throughput: the earliest next grant edge is the IDLE cycle T+3+LOOKUP_LAT.
- rsp_flag_* hold their last captured value until the next capture.
- A req dropped before grant is never granted.
- A req dropped after grant still completes; rsp_valid still pulses.
- Requesters must keep req_x/req_y stable only until gnt; later changes are ignored.
- A requester re-raising req in its own RESP cycle is seen in IDLE, but loses to any other pending requester because rr_ptr has already advanced.
- Coordinates are passed through unmodified; there is no range checking, and out-of-maze values go to the lookup as-is.
- Reset asserted mid-transaction aborts it: no rsp_valid, and the pointer returns to 0.
- busy = (state != IDLE).

Optional Feature:
- MAZE_ARB_FIXED_PRIO_EN defined:
  - Winner is the lowest-index set req bit, so pacman (index 0) always wins.
  - rr_ptr is removed; monsters can starve while pacman requests continuously.
- Not defined: round-robin as above. Any continuously requesting index is granted within NUM_REQ transactions.

Test Plan:
- Reset, then single request: req=4'b0001, req_x[0]=180, req_y[0]=180, lookup model returns L=1,U=0,R=2,D=0 with LAT=1 → gnt=0001 at cycle T+1; lk_x=180, lk_y=180; rsp_valid=0001 at T+3 with rsp_flag_L=1, U=0, R=2, D=0.
- All four requests held constantly → grant order 0,1,2,3,0 with rr_ptr wrap. Each grant is spaced 4 cycles apart (LAT=1). lk_x follows the respective req_x values (20, 300, 100, 180).
- req[2] raised then dropped after gnt → rsp_valid[2] still pulses. req[3] dropped before selection → no gnt[3].
- LOOKUP_LAT=0 and LOOKUP_LAT=3 builds → rsp_valid arrives at T+2 and T+5 respectively. Captured flags match the model value at the last WAIT cycle; values changed after capture do not alter rsp_flag_*.
- rst_n pulsed low during WAIT → all outputs are 0 immediately (asynchronous); no rsp_valid follows. After release, the next grant starts from index 0.
- With MAZE_ARB_FIXED_PRIO_EN, req=4'b1111 held → gnt[0] on every grant and never gnt[1..3]. Dropping req[0] → next grant goes to index 1.
